// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory / device bus between the MEM-stage access
// unit (master) and the memory or device fabric (slave).
// Every request field is held stable while bus_req is high. bus_ack is a
// one-cycle completion strobe, and bus_rdata is valid with it.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine.
// - Decodes store and load controls, and detects misaligned accesses (AdEL/AdES).
// - Issues a single bus transaction and holds the pipeline until it completes.
// - Produces byte enables and lane-replicated store data.
// - Sign- or zero-extends load data.
// Optional feature macro: BUS_TIMEOUT_EN. When it is defined, a REQ phase that
// sees no ack for TIMEOUT cycles is aborted with a one-cycle bus_err pulse.
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    kill,
  input  logic                    load,
  input  logic                    sb,
  input  logic                    sh,
  input  logic                    sw,
  input  logic [2:0]              load_ext_op,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  mem_access_unit_if.master       bus,
  output logic                    stall,
  output logic [31:0]             load_data,
  output logic                    load_valid,
  output logic                    adel,
  output logic                    ades,
  output logic                    bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Selects the byte or halfword lane named by the low address bits, then
  // extends it. Extension codes 5-7 fall through to a full-word load.
  function automatic logic [31:0] extend_load(
    input logic [31:0] rdata,
    input logic [1:0]  lo,
    input logic [2:0]  op
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      3'd1:    res_v = {24'd0, byte_v};
      3'd2:    res_v = {{24{byte_v[7]}}, byte_v};
      3'd3:    res_v = {16'd0, half_v};
      3'd4:    res_v = {{16{half_v[15]}}, half_v};
      default: res_v = rdata;
    endcase
    return res_v;
  endfunction

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ext_op_q, ext_op_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
`ifdef BUS_TIMEOUT_EN
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            bus_err_q, bus_err_d;
`else
  // A TIMEOUT value that does not fit in TO_W bits appears as this named block
  // in the elaborated hierarchy.
  if (TIMEOUT > ((1 << TO_W) - 1)) begin : g_timeout_exceeds_width
  end
`endif

  logic        access_s;
  logic        is_store_s;
  logic        ld_word_s;
  logic        ld_half_s;
  logic        word_op_s;
  logic        half_op_s;
  logic        misaligned_s;
  logic        in_idle_s;
  logic        start_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;

  // Decodes the access: its width class, misalignment, and issue condition.
  always_comb begin
    access_s     = load | sb | sh | sw;
    is_store_s   = (sb | sh | sw) & ~load;
    ld_word_s    = (load_ext_op == 3'd0) | (load_ext_op > 3'd4);
    ld_half_s    = (load_ext_op == 3'd3) | (load_ext_op == 3'd4);
    word_op_s    = load ? ld_word_s : sw;
    half_op_s    = load ? ld_half_s : (sh & ~sw);
    misaligned_s = (word_op_s & (addr[1:0] != 2'b00)) | (half_op_s & addr[0]);
    in_idle_s    = (state_q == ST_IDLE);
    start_s      = in_idle_s & access_s & ~misaligned_s & ~kill;
    adel         = in_idle_s & load & misaligned_s & ~kill;
    ades         = in_idle_s & is_store_s & misaligned_s & ~kill;
    stall        = start_s | (state_q == ST_REQ);
  end

  // Computes byte enables and store data replicated across the byte lanes.
  // A store word takes priority over a halfword, and a halfword over a byte.
  always_comb begin
    be_s    = 4'b1111;
    wdata_s = wdata;
    if (load) begin
      be_s    = 4'b1111;
      wdata_s = wdata;
    end else if (sw) begin
      be_s    = 4'b1111;
      wdata_s = wdata;
    end else if (sh) begin
      be_s    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_s = {2{wdata[15:0]}};
    end else if (sb) begin
      be_s    = 4'b0001 << addr[1:0];
      wdata_s = {4{wdata[7:0]}};
    end else begin
      be_s    = 4'b1111;
      wdata_s = wdata;
    end
  end

  // Next-state logic for the transaction FSM and its latched bus fields.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    ext_op_d     = ext_op_q;
    lo_d         = lo_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d        = cnt_q;
    bus_err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d  = ST_REQ;
          req_d    = 1'b1;
          we_d     = ~load;
          addr_d   = {addr[31:2], 2'b00};
          be_d     = be_s;
          wdata_d  = wdata_s;
          ext_op_d = load_ext_op;
          lo_d     = addr[1:0];
`ifdef BUS_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end else begin
          req_d = 1'b0;
        end
      end
      ST_REQ: begin
        // kill is deliberately not looked at here: a started transaction always finishes.
        if (bus.bus_ack) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            load_data_d  = extend_load(bus.bus_rdata, lo_q, ext_op_q);
            load_valid_d = 1'b1;
          end else begin
            load_valid_d = 1'b0;
          end
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d      = ST_DONE;
          req_d        = 1'b0;
          bus_err_d    = 1'b1;
          load_data_d  = 32'd0;
          load_valid_d = ~we_q;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
`else
        else begin
          req_d = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and bus-field registers. An asynchronous reset drops an outstanding request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      be_q         <= 4'd0;
      wdata_q      <= 32'd0;
      ext_op_q     <= 3'd0;
      lo_q         <= 2'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      ext_op_q     <= ext_op_d;
      lo_q         <= lo_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // REQ wait counter and the one-cycle abort strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;
  assign load_data     = load_data_q;
  assign load_valid    = load_valid_q;

endmodule
